// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the EX->M control/data inputs and the M-stage outputs
// of the MIPS32 memory stage.
//
// Handshake: the EX-side fields (*_e) are taken into the M register on a
// rising clk edge where stall_m=0; while stall_m=1 the M register holds its
// contents and the EX side is expected to hold its fields steady (the hazard
// unit freezes IF/ID/EX). flush_e only has effect on an edge where stall_m=0.
//
// Modports:
//   master - EX/hazard side: drives *_e, observes M outputs.
//   slave  - mem_stage: observes *_e, drives M outputs and state_dbg.
interface mem_stage_if;
  // EX stage inputs
  logic        reg_write_e;
  logic        mem_to_reg_e;
  logic        mem_write_e;
  logic [1:0]  mem_size_e;
  logic        load_unsigned_e;
  logic [31:0] alu_out_e;
  logic [31:0] write_data_e;
  logic [4:0]  write_reg_e;
  logic        flush_e;
  // M stage outputs
  logic [31:0] read_data_m;
  logic [31:0] alu_out_m;
  logic [4:0]  write_reg_m;
  logic        reg_write_m;
  logic        mem_to_reg_m;
  logic        stall_m;
  logic        exc_m;
  // Wait-state FSM: 1 while an access is in its wait phase
  logic        state_dbg;

  modport master (
    output reg_write_e, mem_to_reg_e, mem_write_e, mem_size_e,
           load_unsigned_e, alu_out_e, write_data_e, write_reg_e, flush_e,
    input  read_data_m, alu_out_m, write_reg_m, reg_write_m, mem_to_reg_m,
           stall_m, exc_m, state_dbg
  );

  modport slave (
    input  reg_write_e, mem_to_reg_e, mem_write_e, mem_size_e,
           load_unsigned_e, alu_out_e, write_data_e, write_reg_e, flush_e,
    output read_data_m, alu_out_m, write_reg_m, reg_write_m, mem_to_reg_m,
           stall_m, exc_m, state_dbg
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 memory stage. EX/MEM pipeline register, internal data
// memory with byte/half/word access, sign/zero-extending loads, WAIT_CYCLES
// wait states per access and misalignment handling.
//
// Parameters:
//   DEPTH_WORDS - data memory size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES - extra cycles each load/store occupies in M (0..15)
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset (memory contents are not reset)
//   bus - mem_stage_if.slave: EX inputs (*_e), M outputs (*_m), state_dbg
//
// Build option:
//   MEM_STAGE_MISALIGN_EXC_EN defined   - misaligned accesses raise exc_m,
//     suppress the store, force reg_write_m=0 and do not stall.
//   MEM_STAGE_MISALIGN_EXC_EN undefined - exc_m=0; the offending low address
//     bits are cleared so the access proceeds aligned.
module mem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // M register
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic        mem_write_q;
  logic [1:0]  mem_size_q;
  logic        load_unsigned_q;
  logic [31:0] alu_out_q;
  logic [31:0] write_data_q;
  logic [4:0]  write_reg_q;

  // Wait-state FSM
  state_t      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;

  logic        stall;
  logic        mem_op;
  logic        access;
  logic        exc;
  logic [1:0]  lane;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        store_commit;

  assign mem_op = mem_to_reg_q | mem_write_q;
  assign idx    = alu_out_q[AW+1:2];

`ifdef MEM_STAGE_MISALIGN_EXC_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (mem_size_q == 2'b01)
      misaligned = alu_out_q[0];
    else if (mem_size_q[1])
      misaligned = (alu_out_q[1:0] != 2'b00);
  end
  assign exc    = mem_op & misaligned;
  assign access = mem_op & ~misaligned;
  assign lane   = alu_out_q[1:0];
`else
  assign exc    = 1'b0;
  assign access = mem_op;
  // Force alignment by dropping the low bits the access size cannot use
  always_comb begin
    lane = alu_out_q[1:0];
    if (mem_size_q == 2'b01)
      lane = {alu_out_q[1], 1'b0};
    else if (mem_size_q[1])
      lane = 2'b00;
  end
`endif

  // M register: holds while stalled; a flush captures a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_size_q      <= 2'b00;
      load_unsigned_q <= 1'b0;
      alu_out_q       <= 32'h0;
      write_data_q    <= 32'h0;
      write_reg_q     <= 5'h0;
    end else if (!stall) begin
      reg_write_q     <= bus.reg_write_e  & ~bus.flush_e;
      mem_to_reg_q    <= bus.mem_to_reg_e & ~bus.flush_e;
      mem_write_q     <= bus.mem_write_e  & ~bus.flush_e;
      mem_size_q      <= bus.mem_size_e;
      load_unsigned_q <= bus.load_unsigned_e;
      alu_out_q       <= bus.alu_out_e;
      write_data_q    <= bus.write_data_e;
      write_reg_q     <= bus.write_reg_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'h0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // An access stalls until cnt reaches WC; the completing cycle clears cnt so
  // a following access restarts from zero with no idle gap.
  always_comb begin
    state_n = ST_IDLE;
    cnt_n   = 4'h0;
    stall   = 1'b0;
    if (access && (cnt_q != WC)) begin
      stall   = 1'b1;
      cnt_n   = cnt_q + 4'h1;
      state_n = ST_WAIT;
    end
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    be    = 4'b0000;
    wdata = write_data_q;
    case (mem_size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign store_commit = access & mem_write_q & ~stall;

  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rword[8*lane +: 8];
    h = lane[1] ? rword[31:16] : rword[15:0];
    case (mem_size_q)
      2'b00:   bus.read_data_m = load_unsigned_q ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   bus.read_data_m = load_unsigned_q ? {16'h0, h} : {{16{h[15]}}, h};
      default: bus.read_data_m = rword;
    endcase
  end

  assign bus.alu_out_m    = alu_out_q;
  assign bus.write_reg_m  = write_reg_q;
  assign bus.reg_write_m  = reg_write_q & ~exc;
  assign bus.mem_to_reg_m = mem_to_reg_q;
  assign bus.stall_m      = stall;
  assign bus.exc_m        = exc;
  assign bus.state_dbg    = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int DEPTH = 1024;
  localparam int WAIT  = 3;

  typedef struct {
    bit        rw;
    bit        m2r;
    bit        mw;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [4:0]  wr;
    bit        fl;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference memory: flat byte array, byte address modulo 4*DEPTH
  logic [7:0]  mm [0:4*DEPTH-1];
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] w0;
  int          c0;

  mem_stage_if bus();

  mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(bit rw, bit m2r, bit mw, bit [1:0] size, bit uns,
                                bit [31:0] addr, bit [31:0] wd, bit [4:0] wr, bit fl);
    instr_t x;
    x.rw = rw; x.m2r = m2r; x.mw = mw; x.size = size; x.uns = uns;
    x.addr = addr; x.wd = wd; x.wr = wr; x.fl = fl;
    return x;
  endfunction

  function automatic instr_t ld(bit [1:0] size, bit uns, bit [31:0] addr);
    return mk(1'b1, 1'b1, 1'b0, size, uns, addr, 32'h0, 5'd9, 1'b0);
  endfunction

  function automatic instr_t st(bit [1:0] size, bit [31:0] addr, bit [31:0] wd);
    return mk(1'b0, 1'b0, 1'b1, size, 1'b0, addr, wd, 5'd0, 1'b0);
  endfunction

  function automatic instr_t bubble();
    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input instr_t x);
    bus.reg_write_e     = x.rw;
    bus.mem_to_reg_e    = x.m2r;
    bus.mem_write_e     = x.mw;
    bus.mem_size_e      = x.size;
    bus.load_unsigned_e = x.uns;
    bus.alu_out_e       = x.addr;
    bus.write_data_e    = x.wd;
    bus.write_reg_e     = x.wr;
    bus.flush_e         = x.fl;
  endtask

  // ---------------- reference model ----------------
  // Byte-level view of an instruction's effect; loads push their expected
  // value onto exp_q.
  task automatic model(input instr_t x, output bit exc, output bit acc,
                       output int stall_exp);
    bit          m2r, mw, mis, memop;
    int unsigned n, a, base;
    logic [31:0] val;
    m2r   = x.m2r & ~x.fl;
    mw    = x.mw  & ~x.fl;
    n     = (x.size == 2'b00) ? 1 : (x.size == 2'b01) ? 2 : 4;
    a     = x.addr % (4 * DEPTH);
    mis   = (a % n) != 0;
    memop = m2r | mw;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    exc  = memop & mis;
    acc  = memop & ~mis;
    base = a;
`else
    exc  = 1'b0;
    acc  = memop;
    base = a - (a % n);
`endif
    stall_exp = acc ? WAIT : 0;
    if (acc && m2r) begin
      val = 32'h0;
      for (int k = 0; k < int'(n); k++) val = val | (32'(mm[base + k]) << (8 * k));
      if (n < 4 && !x.uns && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
      exp_q.push_back(val);
    end
    if (acc && mw) begin
      for (int k = 0; k < int'(n); k++) mm[base + k] = 8'(x.wd >> (8 * k));
    end
  endtask

  // Issue at a negedge where stall_m=0; returns at the negedge of the cycle in
  // which the instruction completes in M.
  task automatic run(input instr_t x, output logic [31:0] rdo);
    bit exc, acc;
    int stall_exp, n;
    drive(x);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (bus.stall_m !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    model(x, exc, acc, stall_exp);
    chk("stall_cycles", 32'(n), 32'(stall_exp));
    chk("exc_m", 32'(bus.exc_m), 32'(exc));
    chk("reg_write_m", 32'(bus.reg_write_m), 32'(x.rw & ~x.fl & ~exc));
    chk("mem_to_reg_m", 32'(bus.mem_to_reg_m), 32'(x.m2r & ~x.fl));
    if (!x.fl) begin
      chk("alu_out_m", bus.alu_out_m, x.addr);
      chk("write_reg_m", 32'(bus.write_reg_m), 32'(x.wr));
    end
    if (exp_q.size() > 0) chk("read_data_m", bus.read_data_m, exp_q.pop_front());
    rdo = bus.read_data_m;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    instr_t r;
    drive(bubble());
    #1 rst = 1'b0;

    // Reset held with random EX inputs: M outputs stay cleared
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r = mk(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);
      drive(r);
      #1;
      chk("rst_alu_out_m", bus.alu_out_m, 32'h0);
      chk("rst_write_reg_m", 32'(bus.write_reg_m), 32'h0);
      chk("rst_reg_write_m", 32'(bus.reg_write_m), 32'h0);
      chk("rst_mem_to_reg_m", 32'(bus.mem_to_reg_m), 32'h0);
      chk("rst_stall_m", 32'(bus.stall_m), 32'h0);
      chk("rst_exc_m", 32'(bus.exc_m), 32'h0);
    end
    @(negedge clk);
    drive(bubble());
    rst = 1'b1;
    @(negedge clk);

    // Fill words 0..63 so every later load reads defined data
    for (int w = 0; w < 64; w++) run(st(2'b10, 32'(w * 4), $urandom), rd);

    // Word store / load
    run(st(2'b10, 32'h10, 32'hDEADBEEF), rd);
    run(ld(2'b10, 1'b0, 32'h10), rd);
    chk("word_load_0x10", rd, 32'hDEADBEEF);

    // Byte store and loads
    run(st(2'b00, 32'h13, 32'h00000080), rd);
    run(ld(2'b00, 1'b0, 32'h13), rd);
    chk("byte_load_signed", rd, 32'hFFFFFF80);
    run(ld(2'b00, 1'b1, 32'h13), rd);
    chk("byte_load_unsigned", rd, 32'h00000080);
    run(ld(2'b10, 1'b0, 32'h10), rd);
    chk("word_after_byte", rd, 32'h80ADBEEF);

    // Half store and loads; lower lanes untouched
    run(st(2'b10, 32'h20, 32'h11223344), rd);
    run(st(2'b01, 32'h22, 32'h00008001), rd);
    run(ld(2'b01, 1'b0, 32'h22), rd);
    chk("half_load_signed", rd, 32'hFFFF8001);
    run(ld(2'b01, 1'b1, 32'h22), rd);
    chk("half_load_unsigned", rd, 32'h00008001);
    run(ld(2'b00, 1'b1, 32'h20), rd);
    chk("lane_0x20_kept", rd, 32'h00000044);
    run(ld(2'b00, 1'b1, 32'h21), rd);
    chk("lane_0x21_kept", rd, 32'h00000033);

    // Back-to-back loads: 2*(WAIT+1) M cycles, no idle gap
    c0 = cyc;
    run(ld(2'b10, 1'b0, 32'h10), rd);
    run(ld(2'b10, 1'b0, 32'h20), rd);
    chk("b2b_cycles", 32'(cyc - c0), 32'(2 * (WAIT + 1)));
    chk("b2b_data", rd, 32'h80013344);

    // Address wrap: 0x1000 aliases 0x0000
    run(st(2'b10, 32'h1000, 32'h55667788), rd);
    run(ld(2'b10, 1'b0, 32'h0), rd);
    chk("wrap_alias", rd, 32'h55667788);

    // Misaligned half store, then word load
    run(st(2'b01, 32'h1001, 32'h0000ABCD), rd);
    run(ld(2'b10, 1'b0, 32'h1000), rd);
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    chk("mis_store_suppressed", rd, 32'h55667788);
`else
    chk("mis_store_aligned", rd, 32'h5566ABCD);
`endif
    w0 = rd;

    // Misaligned word load
    run(ld(2'b10, 1'b0, 32'h1002), rd);
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    chk("mis_load_exc", 32'(bus.exc_m), 32'h1);
    chk("mis_load_rw", 32'(bus.reg_write_m), 32'h0);
`else
    chk("mis_load_aligned", rd, w0);
`endif

    // Flushed store must not write
    run(mk(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, 5'd0, 1'b1), rd);
    run(ld(2'b10, 1'b0, 32'h0), rd);
    chk("flush_no_write", rd, w0);

    // Reset in the middle of a stalled store aborts it
    drive(st(2'b10, 32'h40, 32'h12345678));
    @(posedge clk);
    @(negedge clk);
    chk("abort_stall_pre", 32'(bus.stall_m), 32'(WAIT > 0));
    drive(bubble());
    rst = 1'b0;
    #1;
    chk("abort_stall_rst", 32'(bus.stall_m), 32'h0);
    chk("abort_alu_rst", bus.alu_out_m, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(ld(2'b10, 1'b0, 32'h40), rd);

    // Randomised mix in words 0..63 with random upper (aliasing) bits
    for (int i = 0; i < 150; i++) begin
      int sel;
      bit [31:0] a;
      sel = $urandom_range(0, 9);
      a   = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      if (sel < 4)
        r = ld(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a);
      else if (sel < 8)
        r = st(2'($urandom_range(0, 3)), a, $urandom);
      else
        r = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, a, $urandom, 5'($urandom_range(1, 31)), 1'b0);
      r.fl = ($urandom_range(0, 9) == 0);
      run(r, rd);
    end

    drive(bubble());
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised MIPS32 memory stage: EX/MEM pipeline register plus an internal data memory with byte/halfword/word access, sign/zero-extended loads, configurable wait states and misalignment detection. Sits between the execute stage and the writeback register; its stall output feeds the hazard unit, which freezes IF/ID/EX while an access is outstanding.

## Interface
Parameters:
- DEPTH_WORDS, 1024: data memory size in 32-bit words (power of two, ≥4).
- WAIT_CYCLES, 0: extra cycles each load/store occupies in M (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- reg_write_e, mem_to_reg_e, mem_write_e  in  1 each  EX control.
- mem_size_e  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_e  in  1  1 = zero-extend loads, 0 = sign-extend.
- alu_out_e  in  32  effective address or ALU result.
- write_data_e  in  32  store data, right-aligned.
- write_reg_e  in  5  destination register.
- flush_e  in  1  capture a bubble instead of EX contents.
- read_data_m  out  32  extended load data.
- alu_out_m  out  32  registered ALU result.
- write_reg_m  out  5  registered destination.
- reg_write_m, mem_to_reg_m  out  1 each  registered control (reg_write_m gated by exception).
- stall_m  out  1  combinational; access not complete this cycle.
- exc_m  out  1  misaligned access in M this cycle.

## Operation
- M register holds all EX inputs. Loads when stall_m=0; held when stall_m=1. flush_e=1 (with stall_m=0) loads zeros for reg_write, mem_to_reg, mem_write; data fields don't-care.
- Access = mem_to_reg_m or mem_write_m, and not misaligned.
- Wait counter cnt (4 bits), states IDLE (cnt=0) and WAIT (cnt>0). Access with cnt<WAIT_CYCLES: stall_m=1, cnt increments. cnt==WAIT_CYCLES: stall_m=0, access completes, cnt clears. Non-access or misaligned: stall_m=0, cnt stays 0.
- Word index = alu_out_m[log2(DEPTH_WORDS)+1:2]; higher bits ignored (address wraps). Little-endian lanes selected by alu_out_m[1:0].
- Store: commits only on the completing edge, once per instruction. Byte writes lane addr[1:0] with write_data[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0]; word writes all lanes. Other lanes unchanged.
- Load: read_data_m = selected byte/half/word, extended per load_unsigned_m; combinational from registered address and memory; valid when stall_m=0. Non-load: read_data_m is the extended word (don't-care).
- Misaligned: half with addr[0]=1, word with addr[1:0]≠00.

## Timing
- Reset (rst=0, async): every M register, including alu_out_m, write_reg_m, reg_write_m and mem_to_reg_m, clears to 0; cnt=0; so stall_m=0 and exc_m=0. Memory contents are not reset.
- Reset mid-access aborts it; a pending store does not commit.
- Latency: one load/store occupies M for WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives no stall, single-cycle M.
- Load data is valid in the cycle stall_m falls; stored data is readable from the next cycle on.
- Back-to-back accesses: cnt restarts at 0 for the next instruction; no idle gap.
- flush_e during stall_m=1 is ignored; the hazard unit holds flush until the stall clears.

## Configuration
- MEM_STAGE_MISALIGN_EXC_EN defined: a misaligned access raises exc_m=1 for its M cycle. The store is suppressed, reg_write_m is forced 0, and the access does not stall.
- Undefined: exc_m is tied 0. Address bits [0] for half and [1:0] for word are cleared before lane selection, so the access proceeds aligned with normal wait states.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0, stall_m=0. Release, then a word store 0xDEADBEEF to 0x10 and a load from 0x10 → read_data_m=0xDEADBEEF.
- Sub-word: store byte 0x80 to 0x13, then signed byte load 0x13 → 0xFFFFFF80. Unsigned → 0x00000080. Word load 0x10 → 0x80ADBEEF.
- Half: store half 0x8001 to 0x22, then signed half load → 0xFFFF8001, unsigned → 0x00008001. Lanes 0x20/0x21 unchanged.
- Wait states (WAIT_CYCLES=3): load → stall_m high exactly 3 cycles, then data valid. Store during stall → memory written exactly once. Back-to-back load+load → 8 total M cycles.
- Misaligned with macro: word load at 0x1002 → exc_m=1, reg_write_m=0, stall_m=0. Misaligned store to 0x1001 (half) → memory unchanged. Without macro → the same store writes 0x1000.
- Flush and wrap: flush_e with mem_write_e=1 → no write. With DEPTH_WORDS=1024, a store to 0x1000 aliases 0x0000.
